// File: rtl/pad_bank_ctrl.sv
// pad_bank_ctrl: run-time controller for a bank of bidirectional pads.
// Each pad has a mode/pull/filter register, a two-flop synchroniser,
// an optional glitch filter, rise/fall event pulses and a
// break-before-make turnaround whenever its direction mode changes.

module pad_bank_ctrl #(
  parameter  int NUM_PADS   = 8,
  parameter  int FILTER_LEN = 4,
  parameter  int TURNAROUND = 2,
  localparam int ADDR_W     = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [ADDR_W-1:0]   cfg_addr_i,
  input  logic [4:0]          cfg_wdata_i,
  output logic                cfg_err_o,
  input  logic [NUM_PADS-1:0] core_out_i,
  output logic [NUM_PADS-1:0] core_in_o,
  output logic [NUM_PADS-1:0] rise_o,
  output logic [NUM_PADS-1:0] fall_o,
  output logic [NUM_PADS-1:0] pad_oen_o,
  output logic [NUM_PADS-1:0] pad_out_o,
  input  logic [NUM_PADS-1:0] pad_in_i,
  output logic [NUM_PADS-1:0] pad_pu_o,
  output logic [NUM_PADS-1:0] pad_pd_o
);

  // Turnaround counter must hold TURNAROUND; filter counter counts up to
  // FILTER_LEN-1 because the FILTER_LEN-th differing cycle flips the output.
  localparam int TURN_W = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // Pad count widened by one bit so it is representable next to the address.
  localparam logic [ADDR_W:0] NUM_PADS_W = (ADDR_W + 1)'(NUM_PADS);

  typedef enum logic [1:0] {
    MODE_IN  = 2'b00,
    MODE_PP  = 2'b01,
    MODE_OD  = 2'b10,
    MODE_HIZ = 2'b11
  } pad_mode_e;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_TURN   = 1'b1
  } pad_state_e;

  logic                xfer;
  logic                addr_ok;
  logic [NUM_PADS-1:0] wr_sel;
  logic [NUM_PADS-1:0] in_turn;
  pad_mode_e           wr_mode;

  assign xfer    = cfg_valid_i & cfg_ready_o;
  assign addr_ok = ({1'b0, cfg_addr_i} < NUM_PADS_W);
  assign wr_mode = pad_mode_e'(cfg_wdata_i[1:0]);

  // Back-pressure only while the addressed pad is still turning around;
  // out-of-range addresses are always accepted (and flagged).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cfg_ready_o = 1'b1;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (cfg_addr_i == ADDR_W'(i) && in_turn[i]) cfg_ready_o = 1'b0;
    end
  end

  // One-hot write strobe per pad for the accepted transfer.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      wr_sel[i] = xfer && (cfg_addr_i == ADDR_W'(i));
    end
  end

  // Error pulse the cycle after an accepted write to a non-existent pad.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses <=, so every flop in the block
    // samples pre-edge values regardless of statement order.
    if (rst_i) cfg_err_o <= 1'b0;
    else       cfg_err_o <= xfer & ~addr_ok;
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad

    pad_state_e        state_q;
    pad_mode_e         mode_q;
    pad_mode_e         pend_q;
    logic [1:0]        pull_q;
    logic              filt_q;
    logic [TURN_W-1:0] turn_cnt_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              core_in_q;
    logic              core_in_prev_q;
    logic [FCNT_W-1:0] filt_cnt_q;
    logic              rise_q;
    logic              fall_q;
    logic              wr;
    logic              filt_toggle;
    logic              oen;
    logic              out;

    assign wr          = wr_sel[g];
    assign filt_toggle = wr && (cfg_wdata_i[4] != filt_q);
    assign in_turn[g]  = (state_q == ST_TURN);

    // Config registers and the ACTIVE/TURN break-before-make FSM.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q    <= ST_ACTIVE;
        mode_q     <= MODE_IN;
        pend_q     <= MODE_IN;
        pull_q     <= 2'b00;
        filt_q     <= 1'b0;
        turn_cnt_q <= '0;
      end else begin
        if (wr) begin
          pull_q <= cfg_wdata_i[3:2];
          filt_q <= cfg_wdata_i[4];
        end
        case (state_q)
          ST_ACTIVE: begin
            if (wr && (wr_mode != mode_q)) begin
              if (TURNAROUND == 0) begin
                mode_q <= wr_mode;
              end else begin
                state_q    <= ST_TURN;
                pend_q     <= wr_mode;
                turn_cnt_q <= TURN_W'(TURNAROUND);
              end
            end
          end
          ST_TURN: begin
            if (turn_cnt_q == TURN_W'(1)) begin
              state_q <= ST_ACTIVE;
              mode_q  <= pend_q;
            end else begin
              turn_cnt_q <= turn_cnt_q - TURN_W'(1);
            end
          end
          default: state_q <= ST_ACTIVE;
        endcase
      end
    end

    // Synchroniser, glitch filter and edge-event generation.
    always_ff @(posedge clk_i) begin
      // NOTE: the synchroniser and filter flops are reset along with the
      // config so core_in_o and the event pulses start from a known 0.
      if (rst_i) begin
        sync1_q        <= 1'b0;
        sync2_q        <= 1'b0;
        core_in_q      <= 1'b0;
        core_in_prev_q <= 1'b0;
        filt_cnt_q     <= '0;
        rise_q         <= 1'b0;
        fall_q         <= 1'b0;
      end else begin
        sync1_q        <= pad_in_i[g];
        sync2_q        <= sync1_q;
        core_in_prev_q <= core_in_q;
        rise_q         <= core_in_q & ~core_in_prev_q;
        fall_q         <= ~core_in_q & core_in_prev_q;
        if (state_q == ST_TURN || filt_toggle) begin
          // Hold the input value; restart any partial filter run.
          filt_cnt_q <= '0;
        end else if (!filt_q) begin
          core_in_q  <= sync2_q;
          filt_cnt_q <= '0;
        end else if (sync2_q == core_in_q) begin
          filt_cnt_q <= '0;
        end else if (filt_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
          core_in_q  <= sync2_q;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + FCNT_W'(1);
        end
      end
    end

    // Pad drive: forced hi-z during turnaround, otherwise decoded from mode.
    always_comb begin
      oen = 1'b1;
      out = 1'b0;
      if (state_q == ST_ACTIVE) begin
        case (mode_q)
          MODE_PP: begin
            oen = 1'b0;
            out = core_out_i[g];
          end
          MODE_OD: oen = core_out_i[g];
          default: ;
        endcase
      end
    end

    assign pad_oen_o[g] = oen;
    assign pad_out_o[g] = out;
    assign pad_pu_o[g]  = (pull_q == 2'b01);
    assign pad_pd_o[g]  = (pull_q == 2'b10);
    assign core_in_o[g] = core_in_q;
    assign rise_o[g]    = rise_q;
    assign fall_o[g]    = fall_q;
  end

endmodule

// File: doc/pad_bank_ctrl.md
Name: pad_bank_ctrl

Overview:
Parametrised controller for a bank of NUM_PADS bidirectional pads, sitting between core logic and the per-pad IOBUF wrappers. Each pad has a run-time register with these fields:
- direction mode: input, push-pull output, open-drain, or hi-z
- pull-up / pull-down select
- input glitch-filter enable

The block also provides:
- a 2-flop input synchroniser
- break-before-make turnaround on every mode change
- one-cycle rise/fall event pulses per pad

Parameters:
NUM_PADS, 8, number of pads in the bank (>=1)
FILTER_LEN, 4, consecutive stable cycles required by the glitch filter (>=1)
TURNAROUND, 2, hi-z cycles inserted on a mode change (0 allowed)
ADDR_W, max(1,$clog2(NUM_PADS)), config address width (derived, not overridden)

Ports:
clk_i  in  1  bank clock
rst_i  in  1  synchronous reset, active-high
cfg_valid_i  in  1  config write request
cfg_ready_o  out  1  config write accept
cfg_addr_i  in  ADDR_W  target pad index
cfg_wdata_i  in  5  [1:0] mode (00 in, 01 push-pull, 10 open-drain, 11 hi-z); [3:2] pull (00 none, 01 up, 10 down, 11 none); [4] filt_en
cfg_err_o  out  1  one-cycle pulse: write to addr >= NUM_PADS
core_out_i  in  NUM_PADS  core drive value per pad
core_in_o  out  NUM_PADS  synchronised/filtered pad value
rise_o  out  NUM_PADS  one-cycle pulse on core_in_o 0->1
fall_o  out  NUM_PADS  one-cycle pulse on core_in_o 1->0
pad_oen_o  out  NUM_PADS  to IOBUF T (1 = hi-z)
pad_out_o  out  NUM_PADS  to IOBUF I
pad_in_i  in  NUM_PADS  from IOBUF O (asynchronous)
pad_pu_o  out  NUM_PADS  pull-up enable
pad_pd_o  out  NUM_PADS  pull-down enable

Behaviour:
- Reset (rst_i high at a clk_i edge), all pads:
  - mode=00, pull=00, filt_en=0, per-pad FSM ACTIVE
  - pad_oen_o=1, pad_out_o=0, pad_pu_o=pad_pd_o=0
  - sync flops, core_in_o, filter counters, rise_o, fall_o = 0
  - cfg_err_o=0, cfg_ready_o=1
  - Reset mid-turnaround aborts to ACTIVE with reset config.
- Config handshake: transfer when cfg_valid_i & cfg_ready_o.
  - cfg_ready_o = 0 only while the addressed pad is in TURN (combinational on cfg_addr_i).
  - Addr >= NUM_PADS: accepted, no state change, cfg_err_o=1 in the next cycle.
  - pull and filt_en registers update on the edge of the transfer; their outputs change the next cycle.
- Per-pad FSM, states ACTIVE and TURN:
  - Write with new mode == current mode: stay ACTIVE.
  - Write with changed mode, TURNAROUND>0: go to TURN, load counter=TURNAROUND. In TURN, pad_oen_o=1 and pad_out_o=0; counter decrements each cycle; at 1 go to ACTIVE and apply the new mode. This gives exactly TURNAROUND hi-z cycles.
  - TURNAROUND=0: new mode applies in the cycle after the write.
- Output drive in ACTIVE:
  - mode 00, 11: oen=1, out=0
  - mode 01: oen=0, out=core_out_i
  - mode 10: out=0, oen=core_out_i (drive low only)
  - Drive outputs are combinational from the mode register and core_out_i.
- Pulls: pu = (pull==01), pd = (pull==10); pull 11 sets both 0. Both high is never permitted.
- Input path (all modes, including output readback):
  - pad_in_i -> sync1 -> sync2.
  - filt_en=0: core_in_o <= sync2. Pad-to-core_in_o latency is 3 edges.
  - filt_en=1: counter counts cycles with sync2 != core_in_o; it clears when they are equal or when sync2 toggles back. core_in_o flips when the counter reaches FILTER_LEN. Latency is 2+FILTER_LEN edges; pulses shorter than FILTER_LEN cycles are suppressed.
  - In TURN, core_in_o holds and the filter counter clears.
- Events: rise_o/fall_o are registered from the core_in_o change, asserted the cycle after core_in_o changes, 1 cycle wide. Never both high.
- Toggling filt_en mid-count clears the counter. No core_in_o change results from the toggle itself.

Test Plan:
- Reset, no writes; drive pad_in_i[0]=1 at cycle 5 -> core_in_o[0]=1 at cycle 8, rise_o[0] pulse at cycle 9 only; all pad_oen_o=1.
- Write pad 2 wdata=5'b00101 (push-pull, pull-up), TURNAROUND=2 -> pad_oen_o[2]=1 for 2 cycles, then 0 with pad_out_o[2]=core_out_i[2]; pad_pu_o[2]=1 from cycle after write; cfg_ready_o low while cfg_addr_i=2 during TURN.
- Filter on pad 1 (wdata=5'b10000), FILTER_LEN=4: 3-cycle high glitch -> core_in_o[1] stays 0, no pulse; 6-cycle high -> core_in_o[1]=1 exactly 6 cycles after the pad edge.
- Open-drain pad 3 (wdata=5'b00010): core_out_i[3]=0 -> oen=0, out=0; core_out_i[3]=1 -> oen=1.
- Write addr=NUM_PADS -> cfg_err_o one-cycle pulse, no pad config change; pull=11 -> pu=pd=0.
- Assert rst_i during pad 2 TURN -> next cycle pad 2 ACTIVE, mode 00, pad_oen_o[2]=1, cfg_ready_o=1.
